// File: rtl/output_sample_buffer_pkg.sv
// ============================================================================
// Module      : sample_buf_p (package)
// Description : Shared constants and helpers for the output sample buffer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sample_buf_p;

    localparam int DEFAULT_WIDTH     = 14;
    localparam int DEFAULT_DEPTH     = 16;
    localparam int DEFAULT_CNT_WIDTH = 8;

    // Pointer width for a FIFO of the given depth; never narrower than 1 bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/output_sample_buffer_if.sv
// ============================================================================
// Module      : output_sample_buffer_if
// Description : Producer/consumer bundle of the output sample buffer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface output_sample_buffer_if
    import sample_buf_p::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
);
    localparam int LW = ptr_width(DEPTH) + 1;

    logic [WIDTH-1:0]     in_data;
    logic                 in_strobe;
    logic                 in_valid;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [LW-1:0]        level;
    logic                 overflow;
    logic [CNT_WIDTH-1:0] drop_count;

    modport slave (
        input  in_data, in_strobe, in_valid, out_ready,
        output out_data, out_valid, level, overflow, drop_count
    );

    modport master (
        output in_data, in_strobe, in_valid, out_ready,
        input  out_data, out_valid, level, overflow, drop_count
    );

endinterface

`default_nettype wire

// File: rtl/output_sample_buffer_fifo_mem.sv
// ============================================================================
// Module      : sample_fifo_mem
// Description : Simple dual-port register array, synchronous write, async read.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sample_fifo_mem #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic             clk,
    input  wire logic             we_i,
    input  wire logic [AW-1:0]    waddr_i,
    input  wire logic [WIDTH-1:0] wdata_i,
    input  wire logic [AW-1:0]    raddr_i,
    output logic      [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/output_sample_buffer.sv
// ============================================================================
// Module      : output_sample_buffer
// Description : Rate-decoupling FIFO between the filter and the readout path.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module output_sample_buffer
    import sample_buf_p::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input wire logic               clk,
    input wire logic               rst,
    input wire logic               clear,
    output_sample_buffer_if.slave  bus
);

    localparam int AW = ptr_width(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]        c_FULL    = LW'(DEPTH);
    localparam logic [LW-1:0]        c_ONE     = LW'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "output_sample_buffer: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic                 w_push, w_pop, w_full, w_drop, w_wr;
    logic [AW-1:0]        w_rd_addr;
    logic [WIDTH-1:0]     w_rd_data;

    sample_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_wr & ~clear),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.in_data),
        .raddr_i (w_rd_addr),
        .rdata_o (w_rd_data)
    );

    always_comb begin
        w_push    = bus.in_strobe & bus.in_valid;
        w_pop     = out_valid_q & bus.out_ready;
        w_full    = (level_q == c_FULL);
        w_drop    = w_push & w_full & ~w_pop;
        w_wr      = w_push & ~w_drop;
        // On a pop, look one entry ahead so the next head is exposed without a bubble.
        w_rd_addr = w_pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;

        if (w_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({w_wr, w_pop})
            2'b10:   level_d = level_q + c_ONE;
            2'b01:   level_d = level_q - c_ONE;
            default: level_d = level_q;
        endcase

        // A sample written this edge is not yet readable, hence only level_q counts.
        if (w_pop) begin
            out_valid_d = (level_q > c_ONE);
            if (level_q > c_ONE) begin
                out_data_d = w_rd_data;
            end
        end else if (!out_valid_q && level_q != '0) begin
            out_valid_d = 1'b1;
            out_data_d  = w_rd_data;
        end

        if (w_drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != c_CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            end
        end

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
            drop_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.level      = level_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_cnt_q;

endmodule

`default_nettype wire

// File: doc/output_sample_buffer.md
# output_sample_buffer

Rate-decoupling buffer directly downstream of the hybrid fixed-point filter. It captures each valid 14-bit offset-binary filter sample on a one-cycle strobe and stores it in a FIFO. It presents the samples to the consumer (readout/serial interface) over a valid/ready handshake. Overflow is detected and counted, never silently masked.

## Interface
- `width`, default 14: sample width; matches filter output word.
- `depth`, default 16: FIFO capacity in samples; power of two, ≥ 2.
- `cnt_width`, default 8: width of the dropped-sample counter.

Ports:
- `clk`, input, 1: single clock; every register is clocked on its rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `clear`, input, 1: synchronous flush pulse; empties the FIFO and clears statistics.
- `in_data`, input, `width`: filter output sample (offset binary, passed through unchanged).
- `in_strobe`, input, 1: one-cycle pulse marking a new filter output; at most one per DSR cycles.
- `in_valid`, input, 1: filter valid level; samples are ignored while it is low.
- `out_data`, output, `width`: head sample.
- `out_valid`, output, 1: `out_data` holds an unconsumed sample.
- `out_ready`, input, 1: consumer accepts the head sample.
- `level`, output, `$clog2(depth)+1`: number of samples stored and not yet consumed (0..`depth`).
- `overflow`, output, 1: sticky flag; set when any sample is dropped.
- `drop_count`, output, `cnt_width`: saturating count of dropped samples.

## Operation
- Push: `in_strobe && in_valid` in a cycle.
- Pop: `out_valid && out_ready` in a cycle.
- Push when not full: the sample is written at the tail.
- Push when full and no pop in the same cycle: the new sample is dropped. The stored samples are kept (drop-newest policy). `overflow` is set and `drop_count` is incremented; it saturates at 2^`cnt_width`−1.
- Push and pop in the same cycle while full: both take effect, nothing is dropped, and `level` stays at `depth`.
- Push and pop in the same cycle while empty: impossible, because `out_valid` is 0. The push proceeds normally.
- `level` changes by +1 on push only, by −1 on pop only, and is unchanged on push+pop or on no event.
- Pointers are `$clog2(depth)` bits wide and wrap modulo `depth`. Full/empty are derived from `level`, not from pointer equality.
- Order is strictly FIFO. `out_data` holds its value while `out_valid && !out_ready`.
- `out_data` is don't-care when `out_valid`=0. The implementation holds its last value.
- `clear` has priority over push and pop in the same cycle. Any push or pop in that cycle is discarded. On the next cycle `level`=0, `out_valid`=0, `overflow`=0 and `drop_count`=0.
- `rst` has priority over everything, including `clear`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `level`=0, `overflow`=0, `drop_count`=0, and both pointers at 0.
- Latency: a sample pushed into an empty buffer at edge N gives `out_valid`=1 with that sample on `out_data` after edge N+1. This is one cycle of write-to-read latency.
- `level` reflects a push or pop immediately after the edge on which it occurs.
- Back-to-back pops are sustained at one per cycle while data is available.
- A pop at edge N exposes the next sample after edge N, with no bubble.
- If a pop empties the buffer and a push arrives on the same edge, the pushed sample appears one cycle later, per the latency rule.
- `overflow` and `drop_count` update on the edge of the dropping push.
- A reset or `clear` asserted mid-stream discards all stored data. No partial sample is ever emitted.

## Structure
- Package `sample_buf_p` holds:
  - `DEFAULT_WIDTH`=14, `DEFAULT_DEPTH`=16 and `DEFAULT_CNT_WIDTH`=8 constants;
  - a function computing pointer width from depth.
- Sub-module `sample_fifo_mem` is a simple dual-port register array with a synchronous write port and a read port addressed by the read pointer.
- The top level holds the pointers, `level`, output register, handshake logic and overflow statistics.
- The top level elaborates with a fatal error if `depth` is not a power of two or is below 2.

## Test plan
- Reset, then push 0x0123 at edge 5 with `out_ready`=0 → `out_valid`=1 and `out_data`=0x0123 after edge 6; `level`=1.
- Push 16 samples (0x0000..0x000F) with `out_ready`=0, then a 17th (0x3FFF) → `level`=16, `overflow`=1, `drop_count`=1. Drain with `out_ready`=1: 0x0000..0x000F in order, one per cycle; 0x3FFF is never output.
- Full buffer, push 0x0AAA with `out_ready`=1 in the same cycle → nothing dropped, `drop_count` unchanged, `level` stays 16, and 0x0AAA is the last sample drained.
- Strobes with `in_valid`=0 → no pushes, `level` stays 0, `out_valid` stays 0.
- 300 pushes into a full buffer with `cnt_width`=8 → `drop_count` saturates at 255.
- Assert `clear` in the same cycle as a push, with `level`=5 → next cycle `level`=0, `out_valid`=0, `overflow`=0, and the pushed sample never appears.
- Random strobe and `out_ready` patterns over 10k cycles → the scoreboard matches FIFO order with drop-newest, and `level` equals the model's count every cycle.
